// File: rtl/mem_loader.sv
// Program-memory loader: receives a length-prefixed big-endian byte stream and
// writes it into program memory one 16-bit instruction per write, holding the CPU halted meanwhile.
module mem_loader #(
    parameter int          DEPTH = 256,
    parameter logic [15:0] BASE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_address,
    output logic [15:0] wr_data,
    output logic        halt_sys,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        FINISH,
        ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [15:0] count;
    logic [15:0] words;
    logic [15:0] next_addr;
    logic [15:0] full_len;
    logic        accept;
    logic        too_long;
    logic        last_word;

    assign full_len  = {len_hi, in_byte};
    assign too_long  = ({1'b0, full_len} > DEPTH_W);
    assign last_word = ((words + 16'd1) == count);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        halt_sys   = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                halt_sys = 1'b0;
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (full_len == 16'd0) state_next = FINISH;
                    else if (too_long)     state_next = ERROR;
                    else                   state_next = DATA_HI;
                end
            end
            DATA_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DATA_LO;
            end
            DATA_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = last_word ? FINISH : DATA_HI;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The write is registered on the DATA_LO acceptance, so the last word's
    // wr_en lands in the FINISH cycle together with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi     <= '0;
            data_hi    <= '0;
            count      <= '0;
            words      <= '0;
            next_addr  <= BASE;
            wr_en      <= 1'b0;
            wr_address <= BASE;
            wr_data    <= '0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        words     <= '0;
                        count     <= '0;
                        next_addr <= BASE;
                    end
                end
                LEN_HI: begin
                    if (accept) len_hi <= in_byte;
                end
                LEN_LO: begin
                    if (accept) begin
                        count <= full_len;
                        if (too_long) err <= 1'b1;
                    end
                end
                DATA_HI: begin
                    if (accept) data_hi <= in_byte;
                end
                DATA_LO: begin
                    if (accept) begin
                        wr_data    <= {data_hi, in_byte};
                        wr_address <= next_addr;
                        next_addr  <= next_addr + 16'd2;
                        words      <= words + 16'd1;
                        wr_en      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a default-BASE instance plus a BASE=FFFE
// instance fed the same stream to exercise address wrap.
module tb_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, wr_en, halt_sys, done, err;
    logic [15:0] wr_address, wr_data;
    logic        in_ready_w, wr_en_w, halt_sys_w, done_w, err_w;
    logic [15:0] wr_address_w, wr_data_w;

    int vectors;
    int miscompares;

    logic [15:0] qa[$];
    logic [15:0] qd[$];
    logic [15:0] qa_w[$];
    logic [15:0] qd_w[$];

    mem_loader #(.DEPTH(256), .BASE(16'h0000)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .halt_sys(halt_sys), .done(done), .err(err)
    );

    mem_loader #(.DEPTH(256), .BASE(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready_w), .wr_en(wr_en_w), .wr_address(wr_address_w), .wr_data(wr_data_w),
        .halt_sys(halt_sys_w), .done(done_w), .err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            qa.push_back(wr_address);
            qd.push_back(wr_data);
        end
        if (wr_en_w === 1'b1) begin
            qa_w.push_back(wr_address_w);
            qd_w.push_back(wr_data_w);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        qa.delete(); qd.delete(); qa_w.delete(); qd_w.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte after 'gap' idle cycles; optionally pulse start during the gap.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit poke);
        int unsigned n;
        in_valid = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
            start = poke;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) tick();
        vectors++;
        if ({in_ready, wr_en, halt_sys, done, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 00000", {in_ready, wr_en, halt_sys, done, err});
        end
        vectors++;
        if (wr_address !== 16'h0000 || wr_data !== 16'h0000 || wr_address_w !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h data=%h addr_w=%h required 0000 0000 FFFE",
                     wr_address, wr_data, wr_address_w);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        vectors++;
        if (halt_sys !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: halt_sys=%b in_ready=%b required 0 0", halt_sys, in_ready);
        end
    endtask

    task automatic run_basic(input bit gaps);
        logic [7:0] bytes [6];
        bytes = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        clear_logs();
        do_start();
        vectors++;
        if (halt_sys !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_start: halt_sys=%b in_ready=%b required 1 1", halt_sys, in_ready);
        end
        for (int i = 0; i < 6; i++)
            send_byte(bytes[i], gaps ? $urandom_range(0, 3) : 0, gaps);
        vectors++;
        if (wr_en !== 1'b1 || done !== 1'b1 || halt_sys !== 1'b1 || wr_address !== 16'h0002 || wr_data !== 16'hC3D4) begin
            miscompares++;
            $display("FAIL last_write: wr_en=%b done=%b halt=%b addr=%h data=%h required 1 1 1 0002 C3D4",
                     wr_en, done, halt_sys, wr_address, wr_data);
        end
        tick();
        vectors++;
        if (wr_en !== 1'b0 || done !== 1'b0 || halt_sys !== 1'b0 || wr_data !== 16'hC3D4 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_done: wr_en=%b done=%b halt=%b data=%h err=%b required 0 0 0 C3D4 0",
                     wr_en, done, halt_sys, wr_data, err);
        end
        vectors++;
        if (qa.size() != 2 || qa[0] !== 16'h0000 || qd[0] !== 16'hA1B2 || qa[1] !== 16'h0002 || qd[1] !== 16'hC3D4) begin
            miscompares++;
            $display("FAIL write_seq: n=%0d first=(%h,%h) required 2 (0000,A1B2) (0002,C3D4)",
                     qa.size(), qa.size() > 0 ? qa[0] : 16'hxxxx, qd.size() > 0 ? qd[0] : 16'hxxxx);
        end
    endtask

    task automatic test_basic();
        run_basic(1'b0);
    endtask

    task automatic test_gaps();
        run_basic(1'b1);
        vectors++;
        if (halt_sys !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_idle: halt_sys=%b required 0", halt_sys);
        end
    endtask

    task automatic test_wrap();
        run_basic(1'b0);
        vectors++;
        if (qa_w.size() != 2 || qa_w[0] !== 16'hFFFE || qd_w[0] !== 16'hA1B2 || qa_w[1] !== 16'h0000 ||
            qd_w[1] !== 16'hC3D4 || err_w !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_seq: n=%0d err=%b required 2 writes FFFE,0000 err 0", qa_w.size(), err_w);
        end
    endtask

    task automatic test_overflow_and_zero();
        clear_logs();
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        vectors++;
        if (err !== 1'b1 || halt_sys !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow: err=%b halt=%b in_ready=%b wr_en=%b done=%b required 1 1 0 0 0",
                     err, halt_sys, in_ready, wr_en, done);
        end
        tick();
        vectors++;
        if (err !== 1'b1 || halt_sys !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b halt=%b required 1 0", err, halt_sys);
        end
        do_start();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        vectors++;
        if (done !== 1'b1 || wr_en !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len: done=%b wr_en=%b err=%b required 1 0 0", done, wr_en, err);
        end
        tick();
        vectors++;
        if (qa.size() != 0 || halt_sys !== 1'b0) begin
            miscompares++;
            $display("FAIL no_writes: n=%0d halt=%b required 0 0", qa.size(), halt_sys);
        end
    endtask

    task automatic test_depth_limit();
        clear_logs();
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        vectors++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL depth_accept: err=%b in_ready=%b required 0 1", err, in_ready);
        end
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 0, 1'b0);
            send_byte(~8'(i), 0, 1'b0);
        end
        vectors++;
        if (done !== 1'b1 || wr_address !== 16'h01FE || wr_data !== 16'hFF00) begin
            miscompares++;
            $display("FAIL depth_last: done=%b addr=%h data=%h required 1 01FE FF00", done, wr_address, wr_data);
        end
        tick();
        vectors++;
        if (qa.size() != 256 || qa[1] !== 16'h0002 || qd[1] !== 16'h01FE) begin
            miscompares++;
            $display("FAIL depth_count: n=%0d required 256 writes, second (0002,01FE)", qa.size());
        end
    endtask

    task automatic test_reset_midload();
        clear_logs();
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'hA1, 0, 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hB2;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, wr_en, halt_sys, done, err} !== 5'b0 || wr_address !== 16'h0000 || wr_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset: flags=%b addr=%h data=%h required 00000 0000 0000",
                     {in_ready, wr_en, halt_sys, done, err}, wr_address, wr_data);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        vectors++;
        if (qa.size() != 0 || halt_sys !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: n=%0d halt=%b in_ready=%b required 0 0 0", qa.size(), halt_sys, in_ready);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_overflow_and_zero();
        test_gaps();
        test_wrap();
        test_depth_limit();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
